// File: rtl/rr_arb_mux.sv
// N-channel arbiter feeding a single-entry registered output stage.
// MODE 0 arbitrates round-robin from a rotating pointer; MODE 1 is fixed priority, channel 0 first.
module rr_arb_mux #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NCH   = 4,
   parameter int unsigned MODE  = 0,
   parameter int unsigned CW    = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_chan
);

   logic [CW-1:0]    ptr;
   logic [CW-1:0]    gnt_idx;
   logic             gnt_found;
   logic             load_ok;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   int unsigned      idx;

   // Search upward from ptr (or from 0 in fixed-priority mode), wrapping at NCH-1.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = 0; k < int'(NCH); k++) begin
         idx = 32'(k);
         if (MODE == 0) idx = idx + 32'(ptr);
         if (idx >= NCH) idx = idx - NCH;
         if (!gnt_found && in_valid[idx[CW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx[CW-1:0];
         end
      end
   end

   assign load_ok  = !out_valid || out_ready;
   assign xfer     = load_ok && gnt_found && !rst;
   assign sel_data = in_data[32'(gnt_idx)*WIDTH +: WIDTH];

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_chan  <= gnt_idx;
         ptr       <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed and randomized checks of rr_arb_mux: round-robin, fixed priority, stall,
// async reset and an in-order scoreboard on a 3-channel instance.
module tb_rr_arb_mux;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // u0: round-robin, 4 x 32
   logic [127:0] a_in_data;
   logic [3:0]   a_in_valid, a_in_ready;
   logic [31:0]  a_out_data;
   logic         a_out_valid, a_out_ready;
   logic [1:0]   a_out_chan;
   // u1: fixed priority, 4 x 32
   logic [127:0] b_in_data;
   logic [3:0]   b_in_valid, b_in_ready;
   logic [31:0]  b_out_data;
   logic         b_out_valid, b_out_ready;
   logic [1:0]   b_out_chan;
   // u2: round-robin, 3 x 8
   logic [23:0]  c_in_data;
   logic [2:0]   c_in_valid, c_in_ready;
   logic [7:0]   c_out_data;
   logic         c_out_valid, c_out_ready;
   logic [1:0]   c_out_chan;

   rr_arb_mux #(.WIDTH(32), .NCH(4), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_chan(a_out_chan));
   rr_arb_mux #(.WIDTH(32), .NCH(4), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_chan(b_out_chan));
   rr_arb_mux #(.WIDTH(8), .NCH(3), .MODE(0)) u2 (
      .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_chan(c_out_chan));

   task automatic test_reset();
      a_in_valid = 4'hF;
      #2;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
      checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_out_data); end
      checks++; if (a_out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", a_out_chan); end
      checks++; if (a_in_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b want 0000", a_in_ready); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 4'h0) begin
         errors++; $display("FAIL reset_held: valid %b ready %b want 0 0000", a_out_valid, a_in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      a_in_valid = 4'h0;
   endtask

   task automatic test_rr_sequence();
      logic [3:0] exp_rdy;
      for (int i = 0; i < 4; i++) a_in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      a_out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         a_in_valid = 4'hF;
         #1;
         exp_rdy = 4'b0001 << (c % 4);
         checks++; if (a_in_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c%0d: got %b want %b", c, a_in_ready, exp_rdy); end
         @(posedge clk);
         #1;
         checks++; if (a_out_valid !== 1'b1 || a_out_chan !== 2'(c % 4) || a_out_data !== 32'hA000_0000 + 32'(c % 4)) begin
            errors++; $display("FAIL rr_out c%0d: got v%b ch%0d %h want v1 ch%0d", c, a_out_valid, a_out_chan, a_out_data, c % 4);
         end
      end
   endtask

   task automatic test_wrap();
      @(negedge clk); a_in_valid = 4'b0100; #1;
      checks++; if (a_in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_pre: got %b want 0100", a_in_ready); end
      @(negedge clk); a_in_valid = 4'b0010; #1;
      checks++; if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant: got %b want 0010", a_in_ready); end
      @(posedge clk); #1;
      checks++; if (a_out_chan !== 2'd1) begin errors++; $display("FAIL wrap_chan: got %0d want 1", a_out_chan); end
      @(negedge clk); a_in_valid = 4'hF; #1;
      checks++; if (a_in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr: got %b want 0100", a_in_ready); end
      @(posedge clk); #1;
      checks++; if (a_out_chan !== 2'd2) begin errors++; $display("FAIL wrap_next: got %0d want 2", a_out_chan); end
   endtask

   task automatic test_stall();
      @(negedge clk);
      a_in_data[31:0] = 32'hDEAD_BEEF;
      a_in_valid = 4'b0001;
      @(posedge clk); #1;
      checks++; if (a_out_data !== 32'hDEAD_BEEF || a_out_chan !== 2'd0) begin
         errors++; $display("FAIL stall_load: got %h ch%0d want deadbeef ch0", a_out_data, a_out_chan);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); a_out_ready = 1'b0; a_in_valid = 4'hF; #1;
         checks++; if (a_in_ready !== 4'h0) begin errors++; $display("FAIL stall_ready c%0d: got %b want 0000", c, a_in_ready); end
         @(posedge clk); #1;
         checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hDEAD_BEEF || a_out_chan !== 2'd0) begin
            errors++; $display("FAIL stall_hold c%0d: got v%b %h ch%0d want v1 deadbeef ch0", c, a_out_valid, a_out_data, a_out_chan);
         end
      end
      @(negedge clk);
      a_out_ready = 1'b1; a_in_valid = 4'b0100; a_in_data[95:64] = 32'hCAFE_0002;
      #1;
      checks++; if (a_in_ready !== 4'b0100) begin errors++; $display("FAIL stall_release: got %b want 0100", a_in_ready); end
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_chan !== 2'd2 || a_out_data !== 32'hCAFE_0002) begin
         errors++; $display("FAIL stall_replace: got v%b ch%0d %h want v1 ch2 cafe0002", a_out_valid, a_out_chan, a_out_data);
      end
      @(negedge clk); a_in_valid = 4'h0;
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", a_out_valid); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); a_in_valid = 4'b0010; a_out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_chan !== 2'd1) begin
         errors++; $display("FAIL arst_pre: got v%b ch%0d want v1 ch1", a_out_valid, a_out_chan);
      end
      @(negedge clk); a_in_valid = 4'hF; a_out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_out_chan !== 2'd0 || a_in_ready !== 4'h0) begin
         errors++; $display("FAIL arst_clear: got v%b %h ch%0d r%b want v0 0 ch0 r0000", a_out_valid, a_out_data, a_out_chan, a_in_ready);
      end
      #1 rst = 1'b0;
      #1;
      checks++; if (a_in_ready !== 4'b0001) begin errors++; $display("FAIL arst_first_grant: got %b want 0001", a_in_ready); end
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_chan !== 2'd0 || a_out_data !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL arst_first_out: got v%b ch%0d %h want v1 ch0 deadbeef", a_out_valid, a_out_chan, a_out_data);
      end
      @(negedge clk); a_in_valid = 4'h0; a_out_ready = 1'b1;
   endtask

   task automatic test_fixed_prio();
      for (int i = 0; i < 4; i++) b_in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      b_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); b_in_valid = 4'b1010; #1;
         checks++; if (b_in_ready !== 4'b0010) begin errors++; $display("FAIL prio_ready c%0d: got %b want 0010", c, b_in_ready); end
         @(posedge clk); #1;
         checks++; if (b_out_valid !== 1'b1 || b_out_chan !== 2'd1 || b_out_data !== 32'hB000_0001) begin
            errors++; $display("FAIL prio_out c%0d: got v%b ch%0d %h want v1 ch1 b0000001", c, b_out_valid, b_out_chan, b_out_data);
         end
      end
      @(negedge clk); b_in_valid = 4'h0;
   endtask

   task automatic test_random();
      logic [9:0] sb[$];
      logic [9:0] ent;
      logic [2:0] exp_rdy;
      int         mptr = 0;
      int         j;
      for (int c = 0; c < 320; c++) begin
         @(negedge clk);
         if (c < 300) begin
            c_in_valid = 3'($urandom);
            for (int i = 0; i < 3; i++) c_in_data[i*8 +: 8] = 8'($urandom);
            c_out_ready = ($urandom % 4) != 0;
         end else begin
            c_in_valid = 3'b000;
            c_out_ready = 1'b1;
         end
         #1;
         exp_rdy = 3'b000;
         if (!c_out_valid || c_out_ready) begin
            for (int k = 0; k < 3; k++) begin
               j = (mptr + k) % 3;
               if (exp_rdy == 3'b000 && c_in_valid[j]) exp_rdy[j] = 1'b1;
            end
         end
         checks++; if (c_in_ready !== exp_rdy) begin
            errors++; $display("FAIL rand_grant c%0d: got %b want %b (valid %b)", c, c_in_ready, exp_rdy, c_in_valid);
         end
         if (c_out_valid && c_out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rand_extra c%0d: got ch%0d %h want no word", c, c_out_chan, c_out_data);
            end else begin
               ent = sb.pop_front();
               if ({c_out_chan, c_out_data} !== ent) begin
                  errors++; $display("FAIL rand_order c%0d: got ch%0d %h want ch%0d %h", c, c_out_chan, c_out_data, ent[9:8], ent[7:0]);
               end
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i]) begin
               sb.push_back({2'(i), c_in_data[i*8 +: 8]});
               mptr = (i + 1) % 3;
            end
         end
      end
      checks++; if (sb.size() != 0 || c_out_valid !== 1'b0) begin
         errors++; $display("FAIL rand_drain: got %0d pending valid %b want 0 0", sb.size(), c_out_valid);
      end
   endtask

   initial begin
      a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0;
      b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b0;
      c_in_data = '0; c_in_valid = '0; c_out_ready = 1'b0;
      test_reset();
      test_rr_sequence();
      test_wrap();
      test_stall();
      test_async_reset();
      test_fixed_prio();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
